// File: rtl/mult_nib_seq_ctrl.sv
// mult_nib_seq_ctrl: nibble-serial wide unsigned multiplier built on one shared 4x4 multiplier.
// Optional MULT_ZERO_SKIP_EN: zero operands bypass the MUL phase.
module multiplier_4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] z
);
    assign z = x * y;
endmodule

module mult_nib_seq_ctrl #(
    parameter int NIB = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*NIB-1:0] p,
    output logic             busy
);
    localparam int W  = 4*NIB;
    localparam int PW = 8*NIB;
    localparam int N  = NIB*NIB;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t        state, state_n, go;
    logic [W-1:0]  a_q, b_q;
    logic [PW-1:0] acc;
    logic [SW-1:0] step, i, j;
    logic [7:0]    pp;
    logic          last, accept;

    // A nibble walks fastest, B nibble is the outer index
    assign i      = SW'(step % NIB);
    assign j      = SW'(step / NIB);
    assign last   = step == SW'(N-1);
    assign accept = in_valid && in_ready;

`ifdef MULT_ZERO_SKIP_EN
    assign go = (a == '0 || b == '0) ? DONE : MUL;
`else
    assign go = MUL;
`endif

    multiplier_4x4 u_mul (
        .x(a_q[4*i +: 4]),
        .y(b_q[4*j +: 4]),
        .z(pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE) ? (accept ? go : IDLE) :
                  (state == MUL)  ? (last ? DONE : MUL) :
                                    (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        p         = acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            step <= '0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            acc  <= '0;
            step <= '0;
        end else if (state == MUL) begin
            acc  <= acc + (PW'(pp) << (4*(i+j)));
            step <= last ? step : step + 1'b1;
        end
    end
endmodule

// File: tb/tb_mult_nib_seq_ctrl.sv
// tb_mult_nib_seq_ctrl: scoreboard bench for mult_nib_seq_ctrl at NIB=2 and NIB=1.
module tb_mult_nib_seq_ctrl;
`ifdef MULT_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 4;
`endif

    logic clk = 0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] p;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [3:0]  a1, b1;
    logic [7:0]  p1;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] sb[$];
    logic [7:0]  sb1[$];

    mult_nib_seq_ctrl #(.NIB(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    mult_nib_seq_ctrl #(.NIB(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .p(p1), .busy(busy1)
    );

    task automatic accept(input logic [7:0] av, input logic [7:0] bv);
        a = av;
        b = bv;
        in_valid = 1;
        @(negedge clk);
        for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
        sb.push_back(16'(av) * 16'(bv));
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1;
        in_valid = 1;
        a = 8'hFF;
        b = 8'hFF;
        in_valid1 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (p !== 16'h0) $display("FAIL reset_p: got %h want 0000", p); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0) $display("FAIL reset_nib1: got rdy=%b busy=%b want 1/0", in_ready1, busy1); else pass_cnt++;
        in_valid = 0;
        in_valid1 = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: got rdy=%b busy=%b want 1/0", in_ready, busy); else pass_cnt++;
    endtask

    task automatic test_max;
        int lat;
        logic [15:0] e;
        out_ready = 1;
        accept(8'hFF, 8'hFF);
        wait_out(lat);
        total_cnt++; if (lat !== 4) $display("FAIL max_latency: got %0d want 4", lat); else pass_cnt++;
        e = sb.pop_front();
        total_cnt++; if (p !== e || e !== 16'hFE01) $display("FAIL max_p: got %h want FE01", p); else pass_cnt++;
        @(posedge clk);
        #1;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL max_one_cycle: got vld=%b rdy=%b want 0/1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_zero;
        int lat;
        logic [15:0] e;
        out_ready = 1;
        accept(8'h00, 8'h5A);
        wait_out(lat);
        total_cnt++; if (lat !== ZLAT) $display("FAIL zero_latency: got %0d want %0d", lat, ZLAT); else pass_cnt++;
        e = sb.pop_front();
        total_cnt++; if (p !== e || e !== 16'h0000) $display("FAIL zero_p: got %h want 0000", p); else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall;
        int lat;
        logic [15:0] e;
        out_ready = 0;
        accept(8'h12, 8'h34);
        wait_out(lat);
        total_cnt++; if (lat !== 4) $display("FAIL stall_latency: got %0d want 4", lat); else pass_cnt++;
        e = sb.pop_front();
        for (int c = 0; c < 10; c++) begin
            total_cnt++; if (p !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL stall_hold[%0d]: got p=%h vld=%b rdy=%b want 03A8/1/0", c, p, out_valid, in_ready); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (p !== e) $display("FAIL stall_p: got %h want %h", p, e); else pass_cnt++;
        out_ready = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL stall_release: got rdy=%b vld=%b want 1/0", in_ready, out_valid); else pass_cnt++;
    endtask

    task automatic test_busy_ignore;
        int lat;
        logic [15:0] e;
        out_ready = 1;
        accept(8'h0F, 8'hF0);
        a = 8'hAA;
        b = 8'h55;
        in_valid = 1;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL busy_flag[%0d]: got busy=%b rdy=%b want 1/0", lat, busy, in_ready); else pass_cnt++;
            @(negedge clk);
            lat++;
        end
        in_valid = 0;
        total_cnt++; if (lat !== 4) $display("FAIL busy_latency: got %0d want 4", lat); else pass_cnt++;
        e = sb.pop_front();
        total_cnt++; if (p !== e || e !== 16'h0E10) $display("FAIL busy_p: got %h want 0E10", p); else pass_cnt++;
        @(posedge clk);
        #1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL busy_no_capture: got rdy=%b busy=%b want 1/0", in_ready, busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [15:0] e;
        out_ready = 1;
        accept(8'hC3, 8'h7E);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || p !== 16'h0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midrst_outputs: got vld=%b p=%h rdy=%b busy=%b want 0/0000/1/0", out_valid, p, in_ready, busy); else pass_cnt++;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 0;
        accept(8'h03, 8'h05);
        wait_out(lat);
        total_cnt++; if (lat !== 4) $display("FAIL midrst_latency: got %0d want 4", lat); else pass_cnt++;
        e = sb.pop_front();
        total_cnt++; if (p !== e || e !== 16'h000F) $display("FAIL midrst_p: got %h want 000F", p); else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep_nib2;
        localparam int TOT = 1000;
        logic [7:0] cv[8] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'hF0, 8'hFF, 8'h80, 8'h7F};
        int sent = 0, got = 0, cyc = 0;
        logic hs;
        logic [15:0] e;
        sb.delete();
        a = cv[0];
        b = cv[0];
        in_valid = 1;
        while (got < TOT && cyc < 30000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = in_valid && in_ready;
            if (hs) sb.push_back(16'(a) * 16'(b));
            if (out_valid && out_ready) begin
                e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
                total_cnt++; if (p !== e) $display("FAIL sweep2[%0d]: got %h want %h", got, p, e); else pass_cnt++;
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                sent++;
                if (sent < 64) begin
                    a = cv[sent / 8];
                    b = cv[sent % 8];
                end else begin
                    a = 8'($urandom_range(0, 255));
                    b = 8'($urandom_range(0, 255));
                end
                in_valid = sent < TOT;
            end
        end
        in_valid = 0;
        total_cnt++; if (got !== TOT || sb.size() != 0) $display("FAIL sweep2_count: got %0d outputs, %0d pending, want %0d/0", got, sb.size(), TOT); else pass_cnt++;
    endtask

    task automatic test_sweep_nib1;
        int sent = 0, got = 0, cyc = 0;
        logic hs;
        logic [7:0] e;
        sb1.delete();
        a1 = 4'h0;
        b1 = 4'h0;
        in_valid1 = 1;
        while (got < 256 && cyc < 10000) begin
            out_ready1 = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = in_valid1 && in_ready1;
            if (hs) sb1.push_back(8'(a1) * 8'(b1));
            if (out_valid1 && out_ready1) begin
                e = (sb1.size() != 0) ? sb1.pop_front() : 8'hxx;
                total_cnt++; if (p1 !== e) $display("FAIL sweep1[%0d]: got %h want %h", got, p1, e); else pass_cnt++;
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                sent++;
                a1 = 4'(sent >> 4);
                b1 = 4'(sent);
                in_valid1 = sent < 256;
            end
        end
        in_valid1 = 0;
        total_cnt++; if (got !== 256 || sb1.size() != 0) $display("FAIL sweep1_count: got %0d outputs, %0d pending, want 256/0", got, sb1.size()); else pass_cnt++;
    endtask

    initial begin
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        a = 0;
        b = 0;
        in_valid1 = 0;
        out_ready1 = 0;
        a1 = 0;
        b1 = 0;
        test_reset;
        test_max;
        test_zero;
        test_stall;
        test_busy_ignore;
        test_reset_mid;
        test_sweep_nib2;
        test_sweep_nib1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
